param_dcache: RTL and testbench
===============================

Name: param_dcache

Overview:
- Parametrised set-associative, write-back, write-allocate data cache.
- Sits between the pipelined CPU's MEM stage and the line-wide data memory.
- Generalises the earlier direct-mapped cache: configurable sets, ways and line size; per-set LRU; dirty-line writeback; hit/miss statistics counters.
- The memory side uses an ack handshake instead of a fixed-latency count.

Parameters:
ADDR_W, 16, word-address width
DATA_W, 16, CPU word width
LINE_WORDS, 4, words per line (power of 2, ≥2); memory bus = DATA_W*LINE_WORDS
SETS, 4, number of sets (power of 2, ≥1)
WAYS, 2, associativity; legal values 1 or 2

Ports:
Clk  input  1  clock
Reset_N  input  1  synchronous, active-low reset
readC  input  1  CPU read request
writeC  input  1  CPU write request
address  input  ADDR_W  CPU word address
write_data  input  DATA_W  CPU store data
cache_data  output  DATA_W  read data, valid when hit=1
hit  output  1  request served this cycle
stall  output  1  request not yet served; CPU holds request stable
readM  output  1  memory line read
writeM  output  1  memory line write
mem_address  output  ADDR_W  line-aligned memory address (offset bits = 0)
mem_wdata  output  DATA_W*LINE_WORDS  writeback line
mem_rdata  input  DATA_W*LINE_WORDS  refill line
mem_ack  input  1  one-cycle pulse: memory transaction complete
hit_cnt  output  16  hits counted, saturating
miss_cnt  output  16  misses counted, saturating

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remainder.
- Line word k occupies bits [k*DATA_W +: DATA_W].
- Per way/set storage: valid, dirty, tag, line. Per set (WAYS=2 only): one LRU bit naming the least-recently-used way.
- Reset (synchronous, Reset_N=0 at posedge):
  - all valid/dirty/LRU bits cleared; counters = 0; state = IDLE.
  - readM=writeM=0, hit=stall=0, cache_data=0, mem_address=0, mem_wdata=0.
  - Any in-flight memory transaction is abandoned; mem_ack arriving after reset is ignored.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, no request: hit=0, stall=0.
- IDLE, request present, tag match in a valid way (hit):
  - Combinational hit=1, stall=0; cache_data = selected word in the same cycle.
  - Write: the word is updated at the clock edge and dirty is set.
  - The LRU bit is updated to point at the other way.
  - hit_cnt increments, unless the retry flag is set; the retry flag clears.
- IDLE, request present, miss:
  - stall=1, hit=0; miss_cnt increments.
  - Victim = lowest-numbered invalid way, else the LRU way; victim is latched.
  - Next state: WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK:
  - writeM=1; mem_address = {victim tag, index, 0}; mem_wdata = victim line; stall=1.
  - On mem_ack go to REFILL; writeM=0 from the next cycle.
- REFILL:
  - readM=1; mem_address = {request tag, index, 0}; stall=1.
  - On mem_ack: victim line = mem_rdata, tag written, valid=1, dirty=0; retry flag set; return to IDLE.
- The replayed access in IDLE hits one cycle after the ack. Clean miss latency = memory latency + 2 cycles.
- readM and writeM are never high together. Both are held continuously until the ack cycle inclusive.
- readC and writeC both high: treated as a write.
- Changing the request while stall=1 is illegal; behaviour is unspecified.
- Counters saturate at 16'hFFFF.
- WAYS=1: no LRU storage; the victim is always way 0.

Test Plan (SETS=4, WAYS=2, LINE_WORDS=4):
1. Cold read 0x0012 (tag 0x001, idx 0, off 2) → stall=1, readM=1, mem_address=0x0010; ack with mem_rdata=64'h4444_3333_2222_1111 → next cycle hit=1, cache_data=0x3333; miss_cnt=1, hit_cnt=0.
2. Write 0x0013 data 0xBEEF → hit same cycle, no readM/writeM; read 0x0013 next → cache_data=0xBEEF; hit_cnt=2.
3. Read 0x0040 (miss, fills way1), then read 0x0080 → writeM=1, mem_address=0x0010, mem_wdata=64'hBEEF_3333_2222_1111; after ack, readM=1, mem_address=0x0080; miss_cnt=3.
4. Read 0x0000 after step 3 → victim is way1 (clean, tag 0x004) → no writeM, readM directly at 0x0000.
5. Reset_N=0 during REFILL, stray mem_ack afterwards → readM=0, all lookups miss, counters 0, no state change on the stray ack.
6. readC=writeC=1 to a resident address with data 0x1234 → treated as write; a subsequent read returns 0x1234 and the line is dirty (eviction produces writeM).

Source files
------------

// File: rtl/param_dcache.sv
// Set-associative write-back, write-allocate data cache between the MEM stage
// and a line-wide data memory with an ack handshake.
module param_dcache #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 4,
    parameter int WAYS       = 2
) (
    input  logic                         Clk,
    input  logic                         Reset_N,
    input  logic                         readC,
    input  logic                         writeC,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            write_data,
    output logic [DATA_W-1:0]            cache_data,
    output logic                         hit,
    output logic                         stall,
    output logic                         readM,
    output logic                         writeM,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W*LINE_WORDS-1:0] mem_wdata,
    input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
    input  logic                         mem_ack,
    output logic [15:0]                  hit_cnt,
    output logic [15:0]                  miss_cnt
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int IW = (IB > 0) ? IB : 1;
    localparam int TW = ADDR_W - OW - IB;
    localparam int LW = DATA_W * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

    state_t r_state, w_next;

    logic          r_valid [WAYS][SETS];
    logic          r_dirty [WAYS][SETS];
    logic [TW-1:0] r_tag   [WAYS][SETS];
    logic [LW-1:0] r_data  [WAYS][SETS];
    logic          r_victim;
    logic          r_retry;
    logic [15:0]   r_hit_cnt, r_miss_cnt;

    logic [OW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_req, w_hit, w_hit_way, w_victim, w_lru_way;
    logic [LW-1:0] w_hit_line;

    assign w_req = readC | writeC;
    assign w_off = address[OW-1:0];
    assign w_idx = IW'((address >> OW) & ADDR_W'(SETS - 1));
    assign w_tag = TW'(address >> (OW + IB));

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = 1'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins over the LRU choice
    always_comb begin
        w_victim = w_lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx])
                w_victim = 1'(w);
        end
    end

    assign w_hit_line = r_data[w_hit_way][w_idx];

    generate
        if (WAYS > 1) begin : g_lru
            logic r_lru [SETS];
            always_ff @(posedge Clk) begin
                if (!Reset_N) begin
                    for (int s = 0; s < SETS; s++)
                        r_lru[s] <= 1'b0;
                end else if (r_state == S_IDLE && w_req && w_hit) begin
                    r_lru[w_idx] <= ~w_hit_way;
                end
            end
            assign w_lru_way = r_lru[w_idx];
        end else begin : g_no_lru
            assign w_lru_way = 1'b0;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_N)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit)
                    w_next = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx])
                           ? S_WB : S_REFILL;
            end
            S_WB:     if (mem_ack) w_next = S_REFILL;
            S_REFILL: if (mem_ack) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        hit         = 1'b0;
        stall       = 1'b0;
        readM       = 1'b0;
        writeM      = 1'b0;
        cache_data  = '0;
        mem_address = '0;
        mem_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                hit   = w_req & w_hit;
                stall = w_req & ~w_hit;
                if (hit)
                    cache_data = w_hit_line[w_off*DATA_W +: DATA_W];
            end
            S_WB: begin
                writeM      = 1'b1;
                stall       = 1'b1;
                mem_address = (ADDR_W'(r_tag[r_victim][w_idx]) << (OW + IB))
                            | (ADDR_W'(w_idx) << OW);
                mem_wdata   = r_data[r_victim][w_idx];
            end
            S_REFILL: begin
                readM       = 1'b1;
                stall       = 1'b1;
                mem_address = (ADDR_W'(w_tag) << (OW + IB))
                            | (ADDR_W'(w_idx) << OW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
            r_victim   <= 1'b0;
            r_retry    <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req && w_hit) begin
                        if (writeC)
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        // The replay after a refill is not a fresh hit
                        if (!r_retry && r_hit_cnt != 16'hFFFF)
                            r_hit_cnt <= r_hit_cnt + 16'd1;
                        r_retry <= 1'b0;
                    end else if (w_req) begin
                        if (r_miss_cnt != 16'hFFFF)
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        r_victim <= w_victim;
                        r_retry  <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_retry                  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_N) begin
            if (r_state == S_IDLE && w_req && w_hit && writeC)
                r_data[w_hit_way][w_idx][w_off*DATA_W +: DATA_W] <= write_data;
            if (r_state == S_REFILL && mem_ack) begin
                r_data[r_victim][w_idx] <= mem_rdata;
                r_tag[r_victim][w_idx]  <= w_tag;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_param_dcache.sv
// Directed bench for param_dcache: hit vector table plus miss, writeback,
// reset-abandon and read+write corner sequences.
module tb_param_dcache;
    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        readC = 1'b0;
    logic        writeC = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] write_data = '0;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] cache_data;
    logic        hit, stall, readM, writeM;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic [15:0] hit_cnt, miss_cnt;

    param_dcache dut (
        .Clk(Clk), .Reset_N(Reset_N), .readC(readC), .writeC(writeC),
        .address(address), .write_data(write_data), .cache_data(cache_data),
        .hit(hit), .stall(stall), .readM(readM), .writeM(writeM),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        ehit;
        logic        estall;
        logic [15:0] edata;
        logic [15:0] ehc;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        readC      = r;
        writeC     = w;
        address    = a;
        write_data = d;
        #2;
    endtask

    // Miss on a, optional writeback of (wba, wbd), refill with rd; returns
    // in the replay cycle with inputs still held.
    task automatic miss(input string nm, input logic [15:0] a, input bit wb,
                        input logic [15:0] wba, input logic [63:0] wbd,
                        input logic [63:0] rd);
        req(1'b1, 1'b0, a, 16'h0);
        chk({nm, " miss stall"}, 64'(stall), 64'd1);
        chk({nm, " miss hit"}, 64'(hit), 64'd0);
        step(); #2;
        if (wb) begin
            chk({nm, " wb writeM"}, 64'(writeM), 64'd1);
            chk({nm, " wb readM"}, 64'(readM), 64'd0);
            chk({nm, " wb addr"}, 64'(mem_address), 64'(wba));
            chk({nm, " wb data"}, mem_wdata, wbd);
            step();
            mem_ack = 1'b1;
            #2;
            chk({nm, " wb held"}, 64'(writeM), 64'd1);
            step();
            mem_ack = 1'b0;
            #2;
            chk({nm, " wb drop"}, 64'(writeM), 64'd0);
        end else begin
            chk({nm, " no wb"}, 64'(writeM), 64'd0);
        end
        chk({nm, " rf readM"}, 64'(readM), 64'd1);
        chk({nm, " rf addr"}, 64'(mem_address), 64'(a & 16'hFFFC));
        chk({nm, " rf stall"}, 64'(stall), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        #2;
        chk({nm, " rf held"}, 64'(readM), 64'd1);
        step();
        mem_ack = 1'b0;
        #2;
        chk({nm, " replay hit"}, 64'(hit), 64'd1);
        chk({nm, " replay stall"}, 64'(stall), 64'd0);
        chk({nm, " replay readM"}, 64'(readM), 64'd0);
    endtask

    initial begin
        tv[0] = '{1'b0, 1'b1, 16'h0013, 16'hBEEF, 1'b1, 1'b0, 16'h4444, 16'd0};
        tv[1] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'd1};
        tv[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'd2};
        tv[3] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h2222, 16'd3};
        tv[4] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd4};

        step(); step();
        Reset_N = 1'b1;
        #2;
        chk("rst hit", 64'(hit), 64'd0);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst mem", 64'({readM, writeM}), 64'd0);
        chk("rst addr", 64'(mem_address), 64'd0);
        chk("rst wdata", mem_wdata, 64'd0);
        chk("rst data", 64'(cache_data), 64'd0);
        chk("rst cnts", 64'({hit_cnt, miss_cnt}), 64'd0);

        miss("s1", 16'h0012, 1'b0, 16'h0, 64'h0, 64'h4444_3333_2222_1111);
        chk("s1 data", 64'(cache_data), 64'h3333);
        step();
        chk("s1 miss_cnt", 64'(miss_cnt), 64'd1);
        chk("s1 hit_cnt", 64'(hit_cnt), 64'd0);

        for (int i = 0; i < 5; i++) begin
            req(tv[i].rd, tv[i].wr, tv[i].a, tv[i].d);
            chk($sformatf("tv%0d hit", i), 64'(hit), 64'(tv[i].ehit));
            chk($sformatf("tv%0d stall", i), 64'(stall), 64'(tv[i].estall));
            chk($sformatf("tv%0d data", i), 64'(cache_data), 64'(tv[i].edata));
            chk($sformatf("tv%0d hit_cnt", i), 64'(hit_cnt), 64'(tv[i].ehc));
            chk($sformatf("tv%0d mem", i), 64'({readM, writeM}), 64'd0);
            step();
        end

        miss("s3a", 16'h0040, 1'b0, 16'h0, 64'h0, 64'hDDDD_CCCC_BBBB_AAAA);
        chk("s3a data", 64'(cache_data), 64'hAAAA);
        step();
        miss("s3b", 16'h0080, 1'b1, 16'h0010, 64'hBEEF_3333_2222_1111,
             64'h8888_7777_6666_5555);
        chk("s3b data", 64'(cache_data), 64'h5555);
        step();
        chk("s3 miss_cnt", 64'(miss_cnt), 64'd3);

        miss("s4", 16'h0000, 1'b0, 16'h0, 64'h0, 64'hA3A3_A2A2_A1A1_A0A0);
        chk("s4 data", 64'(cache_data), 64'hA0A0);
        step();

        req(1'b1, 1'b1, 16'h0081, 16'h1234);
        chk("s6 rw hit", 64'(hit), 64'd1);
        chk("s6 rw stall", 64'(stall), 64'd0);
        chk("s6 rw mem", 64'({readM, writeM}), 64'd0);
        chk("s6 rw old", 64'(cache_data), 64'h6666);
        step();
        req(1'b1, 1'b0, 16'h0081, 16'h0);
        chk("s6 readback", 64'(cache_data), 64'h1234);
        step();
        req(1'b1, 1'b0, 16'h0000, 16'h0);
        chk("s6 way1 hit", 64'(cache_data), 64'hA0A0);
        step();
        miss("s6 evict", 16'h00C0, 1'b1, 16'h0080, 64'h8888_7777_1234_5555,
             64'hC3C3_C2C2_C1C1_C0C0);
        chk("s6 data", 64'(cache_data), 64'hC0C0);
        step();
        chk("s6 hit_cnt", 64'(hit_cnt), 64'd7);
        chk("s6 miss_cnt", 64'(miss_cnt), 64'd5);

        req(1'b1, 1'b0, 16'h0100, 16'h0);
        step(); #2;
        chk("s5 refill", 64'(readM), 64'd1);
        Reset_N = 1'b0;
        readC   = 1'b0;
        step();
        Reset_N = 1'b1;
        #2;
        chk("s5 readM", 64'(readM), 64'd0);
        chk("s5 stall", 64'(stall), 64'd0);
        chk("s5 addr", 64'(mem_address), 64'd0);
        chk("s5 cnts", 64'({hit_cnt, miss_cnt}), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = '1;
        step();
        mem_ack = 1'b0;
        #2;
        chk("s5 stray mem", 64'({readM, writeM}), 64'd0);
        chk("s5 stray stall", 64'(stall), 64'd0);
        req(1'b1, 1'b0, 16'h0012, 16'h0);
        chk("s5 0012 miss", 64'({hit, stall}), 64'b01);
        req(1'b1, 1'b0, 16'h0080, 16'h0);
        chk("s5 0080 miss", 64'({hit, stall}), 64'b01);
        step(); #2;
        chk("s5 new refill", 64'(readM), 64'd1);
        chk("s5 new addr", 64'(mem_address), 64'h0080);
        chk("s5 miss_cnt", 64'(miss_cnt), 64'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        readC   = 1'b0;
        #2;
        chk("s5 done mem", 64'({readM, writeM}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
